mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, meaning settle/dwell cycles per channel before sampling (legal 1..255).
REQ-002 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin continuous scanning; sampled only in IDLE.
REQ-005 The block SHALL have port stop  input  1  request to end scanning at the next frame boundary.
REQ-006 The block SHALL have port mux_out  input  1  selected data bit returned from the downstream 4:1 mux.
REQ-007 The block SHALL have port sel  output  2  channel select driven to the 4:1 mux.
REQ-008 The block SHALL have port snap  output  4  assembled frame; bit i holds the sample taken with sel==i.
REQ-009 The block SHALL have port snap_valid  output  1  snap holds an unconsumed frame.
REQ-010 The block SHALL have port snap_ready  input  1  consumer accepts snap when high with snap_valid.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port overrun  output  1  sticky; a completed frame was dropped.

Function
REQ-013 The FSM SHALL have states IDLE and SCAN; IDLE->SCAN on start, SCAN->IDLE after channel 3 sample when stop is pending.
REQ-014 On entering SCAN the block SHALL set sel=0 and load the dwell counter with DWELL-1.
REQ-015 In SCAN the dwell counter SHALL decrement each cycle; on the edge where it equals 0, mux_out SHALL be captured into shadow bit [sel], sel SHALL increment modulo 4, and the counter SHALL reload DWELL-1.
REQ-016 Channel i SHALL be sampled at edge k+DWELL*(i+1), where k is the edge that accepted start; snap_valid SHALL rise after edge k+4*DWELL.
REQ-017 With DWELL=1, sel SHALL change every cycle, with one sample per cycle.
REQ-018 On the channel-3 sample, the full frame (shadow bits 2:0 plus the new bit 3) SHALL load into snap if snap_valid is low or snap_ready is high in that cycle.
REQ-019 On the channel-3 sample, if snap_valid is high and snap_ready is low, the frame SHALL be dropped, snap SHALL remain unchanged, and overrun SHALL set.
REQ-020 snap_valid SHALL clear on a cycle with snap_valid and snap_ready high, unless a new frame loads in that same cycle, in which case it SHALL stay high with the new data.
REQ-021 snap and snap_valid SHALL be stable while snap_valid is high and snap_ready is low.
REQ-022 A stop asserted for at least one cycle during SCAN SHALL latch as pending; the current frame SHALL complete, then the FSM SHALL go to IDLE with sel=0.
REQ-023 start while in SCAN SHALL be ignored; start and stop high together in IDLE SHALL run exactly one frame.
REQ-024 In IDLE, sel SHALL hold 0; a pending snap SHALL remain available for handshake.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL set: state=IDLE, sel=0, snap=0, snap_valid=0, busy=0, overrun=0, dwell counter=0, shadow=0, stop-pending=0.
REQ-026 Reset SHALL abandon any partial frame mid-scan; no snap_valid SHALL be produced for that frame.
REQ-027 overrun SHALL clear only by reset.

Configuration
REQ-028 With macro SCAN_CHANGE_DETECT_EN defined, a completed frame equal to the last loaded snap value SHALL be discarded: no snap_valid, no overrun.
REQ-029 With SCAN_CHANGE_DETECT_EN defined, the first frame after reset SHALL always be emitted.
REQ-030 Without SCAN_CHANGE_DETECT_EN, every completed frame SHALL follow REQ-018/019.

Structure
REQ-031 Package mux_scan_pkg SHALL hold the FSM state enum, NCH=4, SEL_W=2, and DWELL_W=8.
REQ-032 The dwell counter SHALL be a sub-module scan_dwell_cnt with ports load, value, and zero flag.

Verification
REQ-033 With DWELL=2 driving a behavioural 4:1 mux with in=4'b1010 and snap_ready=1, a pulsed start SHALL give sel sequence 0,0,1,1,2,2,3,3 and snap=4'b1010 with snap_valid high 8 cycles after start.
REQ-034 With snap_ready held 0 for two frames, the first frame SHALL stay in snap, the second SHALL be dropped, overrun=1, and snap SHALL be unchanged.
REQ-035 With stop pulsed while sel=1, sel SHALL continue to 3, the frame SHALL be emitted, and the block SHALL go to IDLE with busy=0 and sel=0.
REQ-036 With rst asserted while sel=2, all outputs SHALL be 0 on the next cycle and no snap_valid SHALL appear.
REQ-037 With DWELL=1, SCAN_CHANGE_DETECT_EN defined, and in constant 4'b0110, exactly one snap_valid SHALL occur; changing in to 4'b0111 SHALL produce a second one.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the 4:1 mux scan controller.
package mux_scan_pkg;

  localparam int unsigned NCH     = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DWELL_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Down-counter that paces per-channel settle time; zero flags the sample cycle.
module scan_dwell_cnt
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] value,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;

  // zero is kept as a register alongside the count so it is valid on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      cnt_q <= value;
      zero  <= (value == '0);
    end else if (en && !zero) begin
      cnt_q <= cnt_q - DWELL_W'(1);
      zero  <= (cnt_q == DWELL_W'(1));
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux channel by channel and assembles one 4-bit frame per pass.
// Optional feature macro: SCAN_CHANGE_DETECT_EN (drop frames equal to the last loaded snap).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   snap,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_d;
  logic [NCH-2:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   snap_d;
  logic             snap_valid_d;
  logic             overrun_d;
  logic             stop_pend_q, stop_pend_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [NCH-1:0]   frame_c;
  logic             dup_c;

  scan_dwell_cnt u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (RELOAD),
    .zero  (cnt_zero)
  );

  assign frame_c = {mux_out, shadow_q};

`ifdef SCAN_CHANGE_DETECT_EN
  logic have_snap_q, have_snap_d;

  // The first frame after reset has nothing to compare against and always goes out
  assign dup_c = have_snap_q && (frame_c == snap);

  always_ff @(posedge clk) begin
    if (rst) have_snap_q <= 1'b0;
    else     have_snap_q <= have_snap_d;
  end
`else
  assign dup_c = 1'b0;
`endif

  // Next-state, channel stepping and frame hand-off
  always_comb begin
    state_d      = state_q;
    sel_d        = sel;
    shadow_d     = shadow_q;
    snap_d       = snap;
    snap_valid_d = snap_valid;
    overrun_d    = overrun;
    stop_pend_d  = stop_pend_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
    have_snap_d  = have_snap_q;
`endif

    if (snap_valid && snap_ready) snap_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d       = '0;
        stop_pend_d = 1'b0;
        if (start) begin
          state_d     = SCAN;
          cnt_load    = 1'b1;
          stop_pend_d = stop;
        end
      end

      SCAN: begin
        cnt_en = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          sel_d    = sel + SEL_W'(1);
          for (int i = 0; i < int'(NCH) - 1; i++) begin
            if (sel == SEL_W'(i)) shadow_d[i] = mux_out;
          end
          if (sel == SEL_W'(NCH - 1)) begin
            if (!dup_c) begin
              // A frame the consumer is not ready for is dropped, never overwrites snap
              if (!snap_valid || snap_ready) begin
                snap_d       = frame_c;
                snap_valid_d = 1'b1;
`ifdef SCAN_CHANGE_DETECT_EN
                have_snap_d  = 1'b1;
`endif
              end else begin
                overrun_d = 1'b1;
              end
            end
            if (stop_pend_q || stop) begin
              state_d     = IDLE;
              sel_d       = '0;
              stop_pend_d = 1'b0;
              cnt_load    = 1'b0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel         <= '0;
      shadow_q    <= '0;
      snap        <= '0;
      snap_valid  <= 1'b0;
      overrun     <= 1'b0;
      stop_pend_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      shadow_q    <= shadow_d;
      snap        <= snap_d;
      snap_valid  <= snap_valid_d;
      overrun     <= overrun_d;
      stop_pend_q <= stop_pend_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: DWELL=2 instance (b) and DWELL=1 instance (a).
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start_b, stop_b, ready_b;
  logic [3:0] in_b;
  logic [1:0] sel_b;
  logic [3:0] snap_b;
  logic       valid_b, busy_b, ovr_b, mux_b;

  logic       start_a, stop_a, ready_a;
  logic [3:0] in_a;
  logic [1:0] sel_a;
  logic [3:0] snap_a;
  logic       valid_a, busy_a, ovr_a, mux_a;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign mux_b = in_b[sel_b];
  assign mux_a = in_a[sel_a];

  mux_scan_ctrl #(.DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mux_out(mux_b),
    .sel(sel_b), .snap(snap_b), .snap_valid(valid_b), .snap_ready(ready_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  mux_scan_ctrl #(.DWELL(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .mux_out(mux_a),
    .sel(sel_a), .snap(snap_a), .snap_valid(valid_a), .snap_ready(ready_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt;
    int bad;
    rst = 1'b1;
    start_b = 0; stop_b = 0; ready_b = 1; in_b = 4'b1010;
    start_a = 0; stop_a = 0; ready_a = 1; in_a = 4'b1011;
    step(2);
    chk("rst_sel", sel_b, 0);
    chk("rst_snap", snap_b, 0);
    chk("rst_valid", valid_b, 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_ovr", ovr_b, 0);
    rst = 1'b0;
    step(1);

    // Basic frame, DWELL=2, in=1010
    start_b = 1; step(1); start_b = 0;
    for (int j = 0; j < 8; j++) begin
      chk("sel_seq", sel_b, j / 2);
      chk("busy_scan", busy_b, 1);
      if (j == 7) chk("valid_early", valid_b, 0);
      step(1);
    end
    chk("f1_valid", valid_b, 1);
    chk("f1_snap", snap_b, 4'b1010);
    step(1);
    chk("f1_consumed", valid_b, 0);
    step(1);
    // Stop while sel==1; remaining channels see the new input
    in_b = 4'b0110; stop_b = 1; step(1); stop_b = 0;
    chk("stop_sel1", sel_b, 1);
    step(4);
    chk("stop_sel3", sel_b, 3);
    chk("stop_busy3", busy_b, 1);
    step(1);
    chk("stop_valid", valid_b, 1);
    chk("stop_snap", snap_b, 4'b0110);
    chk("stop_busy", busy_b, 0);
    chk("stop_sel0", sel_b, 0);
    step(1);
    chk("idle_valid", valid_b, 0);
    chk("idle_sel", sel_b, 0);

    // Backpressure: frame 1 held, frame 2 dropped
    ready_b = 0; in_b = 4'b1100;
    start_b = 1; step(1); start_b = 0;
    step(8);
    chk("bp_valid1", valid_b, 1);
    chk("bp_snap1", snap_b, 4'b1100);
    chk("bp_ovr0", ovr_b, 0);
    in_b = 4'b0011;
    step(8);
    chk("bp_ovr1", ovr_b, 1);
    chk("bp_snap_hold", snap_b, 4'b1100);
    chk("bp_valid_hold", valid_b, 1);
    stop_b = 1; step(1); stop_b = 0;
    step(7);
    chk("bp_idle", busy_b, 0);
    chk("bp_snap_end", snap_b, 4'b1100);
    ready_b = 1; step(1);
    chk("bp_drain", valid_b, 0);
    chk("ovr_sticky", ovr_b, 1);

    // Reset mid-scan while sel==2
    in_b = 4'b1111;
    start_b = 1; step(1); start_b = 0;
    step(4);
    chk("mid_sel2", sel_b, 2);
    rst = 1; step(1);
    chk("mr_sel", sel_b, 0);
    chk("mr_snap", snap_b, 0);
    chk("mr_valid", valid_b, 0);
    chk("mr_busy", busy_b, 0);
    chk("mr_ovr", ovr_b, 0);
    rst = 0;
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      step(1);
      if (valid_b || busy_b) bad++;
    end
    chk("mr_quiet", bad, 0);

    // DWELL=1 with start+stop together: exactly one frame
    start_a = 1; stop_a = 1; step(1); start_a = 0; stop_a = 0;
    for (int j = 0; j < 4; j++) begin
      chk("d1_sel", sel_a, j);
      step(1);
    end
    chk("d1_valid", valid_a, 1);
    chk("d1_snap", snap_a, 4'b1011);
    chk("d1_busy", busy_a, 0);
    chk("d1_sel0", sel_a, 0);

    // Continuous scan with constant then changed input
    in_a = 4'b0110;
    start_a = 1; step(1); start_a = 0;
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      step(1);
      if (valid_a) cnt++;
    end
`ifdef SCAN_CHANGE_DETECT_EN
    chk("cd_const", cnt, 1);
`else
    chk("all_const", cnt, 4);
`endif
    in_a = 4'b0111;
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      step(1);
      if (valid_a) cnt++;
    end
`ifdef SCAN_CHANGE_DETECT_EN
    chk("cd_change", cnt, 1);
`else
    chk("all_change", cnt, 4);
`endif
    chk("cont_snap", snap_a, 4'b0111);
    stop_a = 1; step(1); stop_a = 0;
    for (int j = 0; j < 10 && busy_a; j++) step(1);
    chk("cont_stopped", busy_a, 0);
    chk("cont_ovr", ovr_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
